// File: rtl/i2c_slave_controller.sv
// I2C target engine: oversampled START/STOP detection, 7-bit address match, byte RX/TX on open-drain SDA.
// Build option I2C_SLAVE_CLOCK_STRETCH_EN: hold SCL low after every ACK slot until the user strobes.
module i2c_slave_controller #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl,
    input  logic [7:0] data_in,
    input  logic       write_enable,
    input  logic       read_enable,
    input  logic       ack_enable,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       addressed,
    output logic       R_Wbar_out,
    output logic       master_nack_received,
    output logic [2:0] i2c_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_ADDR   = 3'd1,
        ACK_ADDR  = 3'd2,
        RX_BYTE   = 3'd3,
        ACK_RX    = 3'd4,
        TX_BYTE   = 3'd5,
        RX_MACK   = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    state_t     state_reg;
    logic [2:0] scl_sync_reg;
    logic [2:0] sda_sync_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic       sda_low_reg;
    logic       scl_low_reg;
    logic       slot_reg;       // second half of a two-edge slot (ACK driven / master ACK seen)
    logic       nack_sent_reg;
    logic       load_strobe;
    logic       release_strobe;

`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
    assign load_strobe    = write_enable;
    assign release_strobe = read_enable;
    assign i2c_scl        = scl_low_reg ? 1'b0 : 1'bz;
`else
    localparam bit STRETCH = 1'b0;
    logic unused_strobes;
    assign unused_strobes = write_enable | read_enable;
    assign load_strobe    = 1'b0;
    assign release_strobe = 1'b0;
    assign i2c_scl        = 1'bz;
`endif

    assign i2c_sda   = sda_low_reg ? 1'b0 : 1'bz;
    assign i2c_state = state_reg;

    logic scl_in, sda_in, scl_rise, scl_fall, start_det, stop_det;
    assign scl_in    = scl_sync_reg[1];
    assign sda_in    = sda_sync_reg[1];
    assign scl_rise  = scl_in & ~scl_sync_reg[2];
    assign scl_fall  = ~scl_in & scl_sync_reg[2];
    assign start_det = scl_in & scl_sync_reg[2] & sda_sync_reg[2] & ~sda_in;
    assign stop_det  = scl_in & scl_sync_reg[2] & ~sda_sync_reg[2] & sda_in;

    // Bits [1:0] are the synchronizer, bit [2] is the previous value for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_reg <= 3'b111;
            sda_sync_reg <= 3'b111;
        end else begin
            scl_sync_reg <= {scl_sync_reg[1:0], i2c_scl};
            sda_sync_reg <= {sda_sync_reg[1:0], i2c_sda};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg            <= IDLE;
            bit_cnt_reg          <= 3'd7;
            shift_reg            <= 8'h00;
            sda_low_reg          <= 1'b0;
            scl_low_reg          <= 1'b0;
            slot_reg             <= 1'b0;
            nack_sent_reg        <= 1'b0;
            data_out             <= 8'h00;
            rx_valid             <= 1'b0;
            tx_req               <= 1'b0;
            addressed            <= 1'b0;
            R_Wbar_out           <= 1'b0;
            master_nack_received <= 1'b0;
        end else begin
            rx_valid             <= 1'b0;
            tx_req               <= 1'b0;
            master_nack_received <= 1'b0;
            if (stop_det) begin
                state_reg   <= IDLE;
                addressed   <= 1'b0;
                sda_low_reg <= 1'b0;
                scl_low_reg <= 1'b0;
                slot_reg    <= 1'b0;
            end else if (start_det) begin
                state_reg   <= RX_ADDR;
                bit_cnt_reg <= 3'd7;
                addressed   <= 1'b0;
                sda_low_reg <= 1'b0;
                scl_low_reg <= 1'b0;
                slot_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    RX_ADDR: if (scl_rise) begin
                        shift_reg <= {shift_reg[6:0], sda_in};
                        if (bit_cnt_reg == 3'd0)
                            state_reg <= (shift_reg[6:0] == SLAVE_ADDR) ? ACK_ADDR : WAIT_STOP;
                        else
                            bit_cnt_reg <= bit_cnt_reg - 3'd1;
                    end
                    ACK_ADDR: if (scl_fall) begin
                        if (!slot_reg) begin
                            slot_reg    <= 1'b1;
                            sda_low_reg <= 1'b1;
                            addressed   <= 1'b1;
                            R_Wbar_out  <= shift_reg[0];
                        end else begin
                            slot_reg    <= 1'b0;
                            bit_cnt_reg <= 3'd7;
                            if (R_Wbar_out) begin
                                state_reg <= TX_BYTE;
                                tx_req    <= 1'b1;
                                if (STRETCH) begin
                                    sda_low_reg <= 1'b0;
                                    scl_low_reg <= 1'b1;
                                end else begin
                                    shift_reg   <= data_in;
                                    sda_low_reg <= ~data_in[7];
                                end
                            end else begin
                                state_reg   <= RX_BYTE;
                                sda_low_reg <= 1'b0;
                                scl_low_reg <= STRETCH;
                            end
                        end
                    end
                    RX_BYTE: if (scl_low_reg) begin
                        if (release_strobe) scl_low_reg <= 1'b0;
                    end else if (scl_rise) begin
                        shift_reg <= {shift_reg[6:0], sda_in};
                        if (bit_cnt_reg == 3'd0) begin
                            data_out  <= {shift_reg[6:0], sda_in};
                            rx_valid  <= 1'b1;
                            state_reg <= ACK_RX;
                            slot_reg  <= 1'b0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg - 3'd1;
                        end
                    end
                    ACK_RX: if (scl_fall) begin
                        if (!slot_reg) begin
                            slot_reg      <= 1'b1;
                            sda_low_reg   <= ack_enable;
                            nack_sent_reg <= ~ack_enable;
                        end else begin
                            slot_reg    <= 1'b0;
                            sda_low_reg <= 1'b0;
                            bit_cnt_reg <= 3'd7;
                            if (nack_sent_reg) begin
                                state_reg <= WAIT_STOP;
                            end else begin
                                state_reg   <= RX_BYTE;
                                scl_low_reg <= STRETCH;
                            end
                        end
                    end
                    TX_BYTE: if (scl_low_reg) begin
                        if (load_strobe) begin
                            shift_reg   <= data_in;
                            sda_low_reg <= ~data_in[7];
                            scl_low_reg <= 1'b0;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 3'd0) begin
                            sda_low_reg <= 1'b0;
                            state_reg   <= RX_MACK;
                            slot_reg    <= 1'b0;
                        end else begin
                            shift_reg   <= {shift_reg[6:0], 1'b0};
                            sda_low_reg <= ~shift_reg[6];
                            bit_cnt_reg <= bit_cnt_reg - 3'd1;
                        end
                    end
                    RX_MACK: if (scl_rise && !slot_reg) begin
                        if (sda_in) begin
                            master_nack_received <= 1'b1;
                            state_reg            <= WAIT_STOP;
                        end else begin
                            slot_reg <= 1'b1;
                        end
                    end else if (scl_fall && slot_reg) begin
                        slot_reg    <= 1'b0;
                        bit_cnt_reg <= 3'd7;
                        state_reg   <= TX_BYTE;
                        tx_req      <= 1'b1;
                        if (STRETCH) begin
                            scl_low_reg <= 1'b1;
                        end else begin
                            shift_reg   <= data_in;
                            sda_low_reg <= ~data_in[7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Directed bench for i2c_slave_controller: a bit-banged open-drain master drives write, read,
// wrong-address, repeated-START, NACK and mid-transfer reset scenarios.
module tb_i2c_slave_controller;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       write_enable = 1'b0;
    logic       read_enable = 1'b0;
    logic       ack_enable = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid, tx_req, addressed, R_Wbar_out, master_nack_received;
    logic [2:0] i2c_state;
    logic       m_sda_low = 1'b0;
    logic       m_scl_low = 1'b0;
    wire        sda_bus, scl_bus;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
    pullup (sda_bus);
    pullup (scl_bus);

    always #5 clk = ~clk;

    i2c_slave_controller dut (
        .clk(clk), .reset(reset), .i2c_sda(sda_bus), .i2c_scl(scl_bus),
        .data_in(data_in), .write_enable(write_enable), .read_enable(read_enable),
        .ack_enable(ack_enable), .data_out(data_out), .rx_valid(rx_valid), .tx_req(tx_req),
        .addressed(addressed), .R_Wbar_out(R_Wbar_out),
        .master_nack_received(master_nack_received), .i2c_state(i2c_state)
    );

    int n_checks = 0;
    int n_fail = 0;
    int rx_cnt = 0, tx_cnt = 0, mnack_cnt = 0;
    int stretch_delay = 8;
    int stretch_max = 0;
    logic [7:0] rx_log [0:15];

    always @(posedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 16] <= data_out;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_req) tx_cnt <= tx_cnt + 1;
        if (master_nack_received) mnack_cnt <= mnack_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL period starting just after a falling edge; returns SDA sampled mid-high.
    task automatic clock_bit(input logic b, output logic sampled);
        int waited;
        tick(Q);
        m_sda_low = ~b;
        tick(Q);
        m_scl_low = 1'b0;
        waited = 0;
        while (scl_bus !== 1'b1 && waited < 4000) begin
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
            if (waited == stretch_delay) begin
                write_enable = 1'b1;
                read_enable  = 1'b1;
                tick(1);
                write_enable = 1'b0;
                read_enable  = 1'b0;
            end else
`endif
            tick(1);
            waited++;
        end
        if (waited > stretch_max) stretch_max = waited;
        if (scl_bus !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL scl_release: scl=%b after %0d clk, required 1", scl_bus, waited);
        end
        tick(Q);
        sampled = sda_bus;
        tick(Q);
        m_scl_low = 1'b1;
    endtask

    task automatic bus_start;
        if (m_scl_low) begin
            tick(Q);
            m_sda_low = 1'b0;
            tick(Q);
            m_scl_low = 1'b0;
            tick(2 * Q);
        end
        m_sda_low = 1'b1;
        tick(2 * Q);
        m_scl_low = 1'b1;
    endtask

    task automatic bus_stop;
        tick(Q);
        m_sda_low = 1'b1;
        tick(Q);
        m_scl_low = 1'b0;
        tick(2 * Q);
        m_sda_low = 1'b0;
        tick(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(v[i], s);
        clock_bit(1'b1, ack);
        $display("[%0t] master wrote %02h, target ack bit %b", $time, v, ack);
    endtask

    // next_data is presented on data_in after the first bit, once the current byte is loaded.
    task automatic recv_byte(input logic mack, input logic [7:0] next_data, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            v[i] = s;
            if (i == 7) data_in = next_data;
        end
        clock_bit(mack, s);
        $display("[%0t] master read %02h, master ack bit %b", $time, v, mack);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(2);
        n_checks++; if (i2c_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", i2c_state); end
        n_checks++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL reset_addressed: got %b want 0", addressed); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        n_checks++; if (R_Wbar_out !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b want 0", R_Wbar_out); end
        n_checks++; if ({rx_valid, tx_req, master_nack_received} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 000", {rx_valid, tx_req, master_nack_received}); end
        n_checks++; if ({sda_bus, scl_bus} !== 2'b11) begin n_fail++; $display("FAIL reset_bus: got %b want 11", {sda_bus, scl_bus}); end
        $display("[%0t] reset checked", $time);
    endtask

    task automatic test_write;
        logic ack;
        int rx0;
        rx0 = rx_cnt;
        ack_enable = 1'b1;
        bus_start();
        send_byte(8'hA0, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
        n_checks++; if ({addressed, R_Wbar_out} !== 2'b10) begin n_fail++; $display("FAIL wr_addressed_rw: got %b want 10", {addressed, R_Wbar_out}); end
        send_byte(8'hA5, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack1: got %b want 0", ack); end
        send_byte(8'h3C, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack2: got %b want 0", ack); end
        bus_stop();
        n_checks++; if (rx_cnt - rx0 !== 2) begin n_fail++; $display("FAIL wr_rx_count: got %0d want 2", rx_cnt - rx0); end
        n_checks++; if (rx_log[rx0 % 16] !== 8'hA5) begin n_fail++; $display("FAIL wr_byte0: got %h want a5", rx_log[rx0 % 16]); end
        n_checks++; if (rx_log[(rx0 + 1) % 16] !== 8'h3C) begin n_fail++; $display("FAIL wr_byte1: got %h want 3c", rx_log[(rx0 + 1) % 16]); end
        n_checks++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL wr_addressed_after_stop: got %b want 0", addressed); end
        n_checks++; if (i2c_state !== 3'd0) begin n_fail++; $display("FAIL wr_state_after_stop: got %0d want 0", i2c_state); end
    endtask

    task automatic test_read;
        logic ack;
        logic [7:0] v;
        int tx0, m0;
        tx0 = tx_cnt;
        m0 = mnack_cnt;
        data_in = 8'h96;
        bus_start();
        send_byte(8'hA1, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
        n_checks++; if (R_Wbar_out !== 1'b1) begin n_fail++; $display("FAIL rd_rw: got %b want 1", R_Wbar_out); end
        tick(5);
        n_checks++; if (tx_cnt - tx0 !== 1) begin n_fail++; $display("FAIL rd_tx_req1: got %0d want 1", tx_cnt - tx0); end
        recv_byte(1'b0, 8'h0F, v);
        n_checks++; if (v !== 8'h96) begin n_fail++; $display("FAIL rd_byte0: got %h want 96", v); end
        recv_byte(1'b1, 8'h00, v);
        n_checks++; if (v !== 8'h0F) begin n_fail++; $display("FAIL rd_byte1: got %h want 0f", v); end
        n_checks++; if (i2c_state !== 3'd7) begin n_fail++; $display("FAIL rd_wait_stop: got %0d want 7", i2c_state); end
        n_checks++; if (tx_cnt - tx0 !== 2) begin n_fail++; $display("FAIL rd_tx_req_count: got %0d want 2", tx_cnt - tx0); end
        n_checks++; if (mnack_cnt - m0 !== 1) begin n_fail++; $display("FAIL rd_master_nack: got %0d want 1", mnack_cnt - m0); end
        bus_stop();
        n_checks++; if (i2c_state !== 3'd0) begin n_fail++; $display("FAIL rd_idle: got %0d want 0", i2c_state); end
    endtask

    task automatic test_wrong_addr;
        logic ack;
        int rx0;
        rx0 = rx_cnt;
        bus_start();
        send_byte(8'hA2, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wa_no_ack: got %b want 1", ack); end
        n_checks++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL wa_addressed: got %b want 0", addressed); end
        n_checks++; if (i2c_state !== 3'd7) begin n_fail++; $display("FAIL wa_wait_stop: got %0d want 7", i2c_state); end
        bus_stop();
        n_checks++; if (i2c_state !== 3'd0) begin n_fail++; $display("FAIL wa_idle: got %0d want 0", i2c_state); end
        n_checks++; if (rx_cnt - rx0 !== 0) begin n_fail++; $display("FAIL wa_rx_count: got %0d want 0", rx_cnt - rx0); end
    endtask

    task automatic test_repeated_start;
        logic ack, s;
        logic [7:0] v;
        int rx0, tx0;
        rx0 = rx_cnt;
        tx0 = tx_cnt;
        data_in = 8'h5A;
        bus_start();
        send_byte(8'hA0, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_addr_ack: got %b want 0", ack); end
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        bus_start();
        $display("[%0t] repeated start after 4 data bits", $time);
        n_checks++; if ({addressed, i2c_state} !== 4'b0_001) begin
            n_fail++; $display("FAIL rs_restart: got addressed=%b state=%0d want 0/1", addressed, i2c_state); end
        send_byte(8'hA1, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_raddr_ack: got %b want 0", ack); end
        n_checks++; if (R_Wbar_out !== 1'b1) begin n_fail++; $display("FAIL rs_rw: got %b want 1", R_Wbar_out); end
        tick(5);
        n_checks++; if (tx_cnt - tx0 !== 1) begin n_fail++; $display("FAIL rs_tx_req: got %0d want 1", tx_cnt - tx0); end
        recv_byte(1'b1, 8'h00, v);
        n_checks++; if (v !== 8'h5A) begin n_fail++; $display("FAIL rs_byte: got %h want 5a", v); end
        n_checks++; if (rx_cnt - rx0 !== 0) begin n_fail++; $display("FAIL rs_partial_dropped: got %0d want 0", rx_cnt - rx0); end
        bus_stop();
    endtask

    task automatic test_nack_and_reset;
        logic ack, s;
        ack_enable = 1'b1;
        bus_start();
        send_byte(8'hA0, ack);
        ack_enable = 1'b0;
        send_byte(8'h11, ack);
        tick(5);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL nk_nack_sent: got %b want 1", ack); end
        n_checks++; if (i2c_state !== 3'd7) begin n_fail++; $display("FAIL nk_wait_stop: got %0d want 7", i2c_state); end
        n_checks++; if (data_out !== 8'h11) begin n_fail++; $display("FAIL nk_data_out: got %h want 11", data_out); end
        bus_stop();
        ack_enable = 1'b1;
        data_in = 8'h00;
        bus_start();
        send_byte(8'hA1, ack);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        tick(5);
        n_checks++; if ({sda_bus, i2c_state} !== 4'b0_101) begin
            n_fail++; $display("FAIL rst_pre_tx: got sda=%b state=%0d want 0/5", sda_bus, i2c_state); end
        reset = 1'b1;
        tick(1);
        n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL rst_sda_release: got %b want 1", sda_bus); end
        n_checks++; if ({i2c_state, addressed, R_Wbar_out} !== 5'b000_00) begin
            n_fail++; $display("FAIL rst_outputs: got state=%0d addr=%b rw=%b want 0/0/0", i2c_state, addressed, R_Wbar_out); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data_out: got %h want 00", data_out); end
        reset = 1'b0;
        $display("[%0t] reset applied mid TX_BYTE", $time);
        tick(Q);
        m_scl_low = 1'b0;
        m_sda_low = 1'b0;
        tick(2 * Q);
    endtask

`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    task automatic test_stretch;
        logic ack;
        logic [7:0] v;
        data_in = 8'hC3;
        bus_start();
        send_byte(8'hA1, ack);
        stretch_delay = 200;
        stretch_max = 0;
        recv_byte(1'b1, 8'h00, v);
        stretch_delay = 8;
        n_checks++; if (stretch_max < 200 || stretch_max > 202) begin
            n_fail++; $display("FAIL st_hold: got %0d clk want 200..202", stretch_max); end
        n_checks++; if (v !== 8'hC3) begin n_fail++; $display("FAIL st_byte: got %h want c3", v); end
        bus_stop();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_repeated_start();
        test_nack_and_reset();
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
        test_stretch();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_controller.md
# i2c_slave_controller

I2C target (slave) engine for the far end of the bus driven by our i2c_controller master. It detects START/STOP, matches a 7-bit address, ACKs it, and moves bytes between the bus and a byte-wide user interface. It runs from the system clock, oversampling SCL and SDA, and drives SDA open-drain; with the configuration macro defined it also drives SCL open-drain.

## Interface
- SLAVE_ADDR, 7'h50, own 7-bit address
- clk  input  1  system clock; must be ≥ 20× SCL frequency
- reset  input  1  synchronous, active-high
- i2c_sda  inout  1  open-drain, driven low or `z`
- i2c_scl  inout  1  sampled only; driven low only when stretching is compiled in
- data_in  input  8  byte to return on a read
- write_enable  input  1  strobe that loads data_in (stretch builds only)
- read_enable  input  1  strobe that acknowledges data_out (stretch builds only)
- ack_enable  input  1  level; 1 = ACK received data bytes, 0 = NACK
- data_out  output  8  last received data byte
- rx_valid  output  1  1-cycle pulse when data_out updates
- tx_req  output  1  1-cycle pulse when a byte is about to be transmitted
- addressed  output  1  high from address ACK until STOP or repeated START
- R_Wbar_out  output  1  R/W bit of the current transfer
- master_nack_received  output  1  pulse when the master NACKs a read byte
- i2c_state  output  3  FSM state (debug)

## Operation
- Inputs pass through a 2-FF synchronizer. Edges are detected on the synchronized copies.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data: sampled on the SCL rising edge. SDA is changed only on the SCL falling edge.
- States: IDLE(0), RX_ADDR(1), ACK_ADDR(2), RX_BYTE(3), ACK_RX(4), TX_BYTE(5), RX_MACK(6), WAIT_STOP(7).
- IDLE → RX_ADDR on START. Shift 8 bits MSB first.
  - If addr[7:1] == SLAVE_ADDR: → ACK_ADDR. Drive SDA low for one SCL period. Set addressed and R_Wbar_out.
  - Otherwise: → WAIT_STOP.
- After ACK_ADDR, R_Wbar_out selects the branch:
  - R_Wbar_out = 0 → RX_BYTE.
  - R_Wbar_out = 1 → TX_BYTE. Pulse tx_req and latch data_in in the same cycle as the ACK-ending SCL falling edge.
- RX_BYTE: after bit 0 is sampled, update data_out and pulse rx_valid. → ACK_RX.
  - ACK_RX drives SDA low if ack_enable = 1 (sampled at the falling edge after bit 0), else releases it.
  - After ACK_RX: → RX_BYTE, or → WAIT_STOP if a NACK was sent.
- TX_BYTE: put bit 7 on SDA first, then shift on each falling edge. After bit 0, release SDA. → RX_MACK.
- RX_MACK:
  - Master ACK (SDA = 0): → TX_BYTE with a new tx_req.
  - Master NACK: pulse master_nack_received. → WAIT_STOP.
- STOP in any state → IDLE. Clear addressed; release SDA.
- START in any state other than IDLE (repeated START): → RX_ADDR. Discard any partial byte; no rx_valid; clear addressed.
- SDA drive always matches the SCL-falling-edge schedule. SDA is never changed while SCL is high.

## Timing
- Reset values:
  - sda released, scl released, state IDLE.
  - data_out 0, all pulses 0, addressed 0, R_Wbar_out 0.
- Reset mid-transfer releases SDA and SCL on the next clk edge.
- Edge-detect latency: 3 clk from a pin change to internal event.
  - SDA updates 3 clk after the physical SCL fall; hold time = 3 clk.
  - rx_valid asserts 3 clk after the 8th SCL rise.
- tx_req is asserted on the clk that loads the shift register. data_in must already be valid then (non-stretch builds).
- Byte counter is 3 bits, counting 7→0. Wrap to 7 happens only on an ACK-slot transition.

## Configuration
- I2C_SLAVE_CLOCK_STRETCH_EN defined:
  - After each address/data ACK slot, hold SCL low from the falling edge.
    - Read: release after write_enable (data_in latched that cycle).
    - Write: release after read_enable.
  - A strobe arriving while not stretching is ignored.
- I2C_SLAVE_CLOCK_STRETCH_EN undefined:
  - SCL is never driven; write_enable and read_enable are unused.
  - Overrun is silent: data_out is overwritten by the next byte.

## Test plan
- Write to 0x50 with bytes 0xA5, 0x3C, then STOP, ack_enable = 1 → two ACKs, rx_valid twice with data_out 0xA5 then 0x3C, addressed low after STOP.
- Read from 0x50, data_in 0x96 then 0x0F, master ACK then NACK → SDA bits match 0x96, 0x0F; two tx_req pulses; master_nack_received once; state WAIT_STOP→IDLE.
- Address 0x51 → no ACK (SDA high in 9th clock), addressed stays 0, no rx_valid, IDLE after STOP.
- Repeated START after 4 bits of a write byte, then read of 0x50 → partial byte dropped, R_Wbar_out = 1, tx_req fires.
- ack_enable = 0 on the first data byte → NACK sent, then WAIT_STOP; reset asserted mid-TX_BYTE → SDA released the next clk, all outputs at reset values.
- Stretch build: delay write_enable by 200 clk → SCL held low 200 clk after the ACK fall, released the cycle after the strobe, byte transmitted correctly.
